// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pkg : shared types and helpers for the MIPS branch predictor     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package bp_pkg;

  // Ceiling log2 for sizing indices from a power-of-two depth.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counters are carried at the widest supported width (4 bits); callers truncate.
  function automatic logic [3:0] sat_step(input logic [3:0] cnt, input logic up,
                                          input int unsigned cnt_w);
    logic [3:0] cnt_max;
    cnt_max = 4'((1 << cnt_w) - 1);
    if (up) begin
      return (cnt == cnt_max) ? cnt : cnt + 4'd1;
    end
    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

  // Weakly-not-taken: one below the taken threshold.
  function automatic logic [3:0] cnt_init(input int unsigned cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Tag field sized for the smallest table; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_sat_counter_table : PHT of saturating counters, async read       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  localparam int IDX_W  = clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_up
);

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(cnt_init(CNT_W));

  logic [CNT_W-1:0] r_cnt [ENTRIES];
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next = CNT_W'(sat_step(4'(r_cnt[wr_idx]), wr_up, CNT_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= c_cnt_init;
      end
    end else if (wr_en) begin
      r_cnt[wr_idx] <= w_cnt_next;
    end
  end

  // Read sees the pre-write value during a same-cycle write to the same entry.
  assign rd_cnt = r_cnt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/mips_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_branch_predictor : gshare/bimodal PHT plus direct-mapped BTB   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mips_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GSHARE  = 1,
  parameter int GHR_W   = clog2(ENTRIES),
  localparam int IDX_W  = clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_f,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic             pred_hit,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target
);

  btb_entry_t       r_btb [ENTRIES];
  btb_entry_t       w_entry;
  logic [IDX_W-1:0] w_btb_ridx;
  logic [IDX_W-1:0] w_btb_widx;
  logic [IDX_W-1:0] w_pht_ridx;
  logic [CNT_W-1:0] w_cnt;
  logic             w_unused;

  assign w_btb_ridx = pc_f[IDX_W+1:2];
  assign w_btb_widx = upd_pc[IDX_W+1:2];
  assign w_unused   = ^{pc_f[1:0], upd_pc[1:0]};

  generate
    if (GSHARE != 0) begin : g_gshare
      logic [GHR_W-1:0] r_ghr;
      logic [GHR_W-1:0] w_ghr_next;

      if (GHR_W > 1) begin : g_shift
        assign w_ghr_next = {r_ghr[GHR_W-2:0], upd_taken};
      end else begin : g_single
        assign w_ghr_next = upd_taken;
      end

      // History advances only on resolved branches, never speculatively.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ghr <= '0;
        end else if (upd_valid) begin
          r_ghr <= w_ghr_next;
        end
      end

      assign w_pht_ridx = w_btb_ridx ^ IDX_W'(r_ghr);
    end else begin : g_bimodal
      assign w_pht_ridx = w_btb_ridx;
    end
  endgenerate

  bp_sat_counter_table #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_pht (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (w_pht_ridx),
    .rd_cnt (w_cnt),
    .wr_en  (upd_valid),
    .wr_idx (upd_idx),
    .wr_up  (upd_taken)
  );

  // Not-taken outcomes leave the BTB alone; the counter steers a stale entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      r_btb[w_btb_widx] <= '{valid:  1'b1,
                             tag:    30'(upd_pc[31:IDX_W+2]),
                             target: upd_target};
    end
  end

  assign w_entry     = r_btb[w_btb_ridx];
  assign pred_hit    = w_entry.valid && (w_entry.tag == 30'(pc_f[31:IDX_W+2]));
  assign pred_target = pred_hit ? w_entry.target : 32'h0;
  assign pred_taken  = pred_hit && w_cnt[CNT_W-1];
  assign pred_idx    = w_pht_ridx;

endmodule
`default_nettype wire
